skew_buffer_bank: RTL

SKEW_BUFFER_BANK -- requirements
Module: skew_buffer_bank

---
 rtl/skew_buffer_bank.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/skew_buffer_bank.sv
// skew_buffer_bank: a bank of per-lane delay lines that can either skew
// or de-skew a stream of columns. Each lane taps its delay line at a depth
// that depends on the lane index and on the mode latched at stream start.
// After the last column the bank flushes itself with zeros, then pulses done.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, mode         begin a stream (IDLE only); mode 0=SKEW, 1=DESKEW
//   shift_en, last      accept one column (RUN only); mark the final column
//   data_in, valid_in   input column, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   data_out, valid_out per-lane tap, same packing as the inputs
//   out_strobe          high in the cycle after any shift edge
//   busy, done          stream in progress; one-cycle drain-complete pulse
module skew_buffer_bank #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CHANNELS   = 16,
    parameter int unsigned BASE_DEPTH = 27,
    parameter int unsigned SKEW_STEP  = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           mode,
    input  logic                           shift_en,
    input  logic                           last,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
    input  logic [CHANNELS-1:0]            valid_in,
    output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
    output logic [CHANNELS-1:0]            valid_out,
    output logic                           out_strobe,
    output logic                           busy,
    output logic                           done
);

    localparam int unsigned MAX_DEPTH = BASE_DEPTH + (CHANNELS - 1) * SKEW_STEP;
    localparam int unsigned CNT_W     = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    localparam int unsigned BUS_W     = CHANNELS * DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               strobe_q;
    logic               shift_c;
    logic [BUS_W-1:0]   col_data_c;
    logic [CHANNELS-1:0] col_vld_c;

    logic [DATA_WIDTH-1:0] stg_data_q [CHANNELS][MAX_DEPTH];
    logic [MAX_DEPTH-1:0]  stg_vld_q  [CHANNELS];

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            strobe_q <= shift_c;
        end
    end

    // Next-state, shift decision and drain counting
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        shift_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    mode_d  = mode;
                end
            end
            S_RUN: begin
                if (shift_en) begin
                    shift_c = 1'b1;
                    if (last) begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                    end
                end
            end
            S_DRAIN: begin
                shift_c = 1'b1;
                if (cnt_q == CNT_W'(MAX_DEPTH - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Drain flushes zeros so every stage is empty when the stream ends
    always_comb begin
        col_data_c = data_in;
        col_vld_c  = valid_in;
        if (state_q == S_DRAIN) begin
            col_data_c = '0;
            col_vld_c  = '0;
        end
    end

    // Delay lines: all lanes advance together on a shift edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < int'(CHANNELS); ch++) begin
                for (int k = 0; k < int'(MAX_DEPTH); k++) begin
                    stg_data_q[ch][k] <= '0;
                end
                stg_vld_q[ch] <= '0;
            end
        end else if (shift_c) begin
            for (int ch = 0; ch < int'(CHANNELS); ch++) begin
                stg_data_q[ch][0] <= col_data_c[ch*DATA_WIDTH +: DATA_WIDTH];
                stg_vld_q[ch][0]  <= col_vld_c[ch];
                for (int k = 1; k < int'(MAX_DEPTH); k++) begin
                    stg_data_q[ch][k] <= stg_data_q[ch][k-1];
                    stg_vld_q[ch][k]  <= stg_vld_q[ch][k-1];
                end
            end
        end
    end

    // Per-lane tap: the stage index is fixed per lane, mode picks the order
    for (genvar ch = 0; ch < int'(CHANNELS); ch++) begin : g_tap
        localparam int unsigned TAP_SKEW   = BASE_DEPTH + int'(ch) * SKEW_STEP - 1;
        localparam int unsigned TAP_DESKEW = BASE_DEPTH + (CHANNELS - 1 - int'(ch)) * SKEW_STEP - 1;
        assign data_out[ch*DATA_WIDTH +: DATA_WIDTH] =
            mode_q ? stg_data_q[ch][TAP_DESKEW] : stg_data_q[ch][TAP_SKEW];
        assign valid_out[ch] =
            mode_q ? stg_vld_q[ch][TAP_DESKEW] : stg_vld_q[ch][TAP_SKEW];
    end

    assign out_strobe = strobe_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;

endmodule
